// File: rtl/scale_coord_gen.sv
// Source-coordinate generator for the RGB scalers. Each accepted frame start
// latches the sizes, derives fixed-point step ratios with one shared serial
// restoring divider, then streams one source coordinate per destination pixel
// over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; zero-size starts are rejected with cfg_err
// DIV_X | serial division for step_x, one quotient bit per clock
// DIV_Y | serial division for step_y, plus one cycle to clear the accumulators
// RUN   | coordinates offered downstream until the eof transfer
// DONE  | single cycle pulsing frame_done
module scale_coord_gen #(
  parameter int C_COORD_W = 12,
  parameter int C_FRAC_W  = 8
) (
  input  logic                 clk_in1,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [C_COORD_W-1:0] src_width,
  input  logic [C_COORD_W-1:0] src_height,
  input  logic [C_COORD_W-1:0] dst_width,
  input  logic [C_COORD_W-1:0] dst_height,
  input  logic                 coord_ready,
  output logic                 coord_valid,
  output logic [C_COORD_W-1:0] x_int,
  output logic [C_COORD_W-1:0] y_int,
  output logic [C_FRAC_W-1:0]  x_frac,
  output logic [C_FRAC_W-1:0]  y_frac,
  output logic                 sof,
  output logic                 eof,
  output logic                 sol,
  output logic                 eol,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 cfg_err
);

  localparam int Q_W   = C_COORD_W + C_FRAC_W;
  localparam int CNT_W = $clog2(Q_W + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(Q_W - 1);
  localparam logic [CNT_W-1:0]     CNT_END  = CNT_W'(Q_W);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [C_COORD_W-1:0] ONE_C    = C_COORD_W'(1);

  typedef enum logic [2:0] {IDLE, DIV_X, DIV_Y, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [C_COORD_W-1:0] src_h_q, dst_w_q, dst_h_q;
  logic [Q_W-1:0]       step_x_q, step_y_q;
  logic [Q_W-1:0]       div_quo_q;
  logic [C_COORD_W-1:0] div_rem_q;
  logic [CNT_W-1:0]     div_cnt_q;
  logic [Q_W-1:0]       x_acc_q, y_acc_q;
  logic [C_COORD_W-1:0] dx_q, dy_q;
  logic                 cfg_err_q;

  logic                 size_ok, xfer, last_col, last_row;
  logic [C_COORD_W:0]   rem_shift, divisor;
  logic                 div_ge;
  logic [C_COORD_W-1:0] rem_next;
  logic [Q_W-1:0]       quo_next;

  assign size_ok = (|src_width) && (|src_height) && (|dst_width) && (|dst_height);
  assign last_col = (dx_q == dst_w_q - ONE_C);
  assign last_row = (dy_q == dst_h_q - ONE_C);
  assign xfer     = coord_valid && coord_ready;

  // One restoring-division step: the dividend shifts out of the quotient
  // register MSB-first while quotient bits shift in at the LSB. The
  // remainder always ends below the divisor, so it fits C_COORD_W bits.
  assign rem_shift = {div_rem_q, div_quo_q[Q_W-1]};
  assign divisor   = (state_q == DIV_X) ? {1'b0, dst_w_q} : {1'b0, dst_h_q};
  assign div_ge    = (rem_shift >= divisor);
  assign rem_next  = div_ge ? (rem_shift[C_COORD_W-1:0] - divisor[C_COORD_W-1:0])
                            : rem_shift[C_COORD_W-1:0];
  assign quo_next  = {div_quo_q[Q_W-2:0], div_ge};

  // State register.
  always_ff @(posedge clk_in1 or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && size_ok) state_d = DIV_X;
      DIV_X:   if (div_cnt_q == CNT_LAST) state_d = DIV_Y;
      DIV_Y:   if (div_cnt_q == CNT_END) state_d = RUN;
      RUN:     if (xfer && last_col && last_row) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Size latching, serial divider, and coordinate accumulators.
  always_ff @(posedge clk_in1 or negedge rst_n) begin
    if (!rst_n) begin
      src_h_q   <= '0;
      dst_w_q   <= '0;
      dst_h_q   <= '0;
      step_x_q  <= '0;
      step_y_q  <= '0;
      div_quo_q <= '0;
      div_rem_q <= '0;
      div_cnt_q <= '0;
      x_acc_q   <= '0;
      y_acc_q   <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= (state_q == IDLE) && start && !size_ok;
      case (state_q)
        IDLE: begin
          if (start && size_ok) begin
            src_h_q   <= src_height;
            dst_w_q   <= dst_width;
            dst_h_q   <= dst_height;
            div_quo_q <= {src_width, {C_FRAC_W{1'b0}}};
            div_rem_q <= '0;
            div_cnt_q <= '0;
          end
        end
        DIV_X: begin
          if (div_cnt_q == CNT_LAST) begin
            // Last x bit: capture step_x and preload the divider for y.
            step_x_q  <= quo_next;
            div_quo_q <= {src_h_q, {C_FRAC_W{1'b0}}};
            div_rem_q <= '0;
            div_cnt_q <= '0;
          end else begin
            div_quo_q <= quo_next;
            div_rem_q <= rem_next;
            div_cnt_q <= div_cnt_q + CNT_ONE;
          end
        end
        DIV_Y: begin
          if (div_cnt_q != CNT_END) begin
            div_quo_q <= quo_next;
            div_rem_q <= rem_next;
            div_cnt_q <= div_cnt_q + CNT_ONE;
            if (div_cnt_q == CNT_LAST) step_y_q <= quo_next;
          end else begin
            x_acc_q <= '0;
            y_acc_q <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
          end
        end
        RUN: begin
          if (xfer) begin
            if (last_col) begin
              dx_q    <= '0;
              x_acc_q <= '0;
              if (last_row) begin
                dy_q    <= '0;
                y_acc_q <= '0;
              end else begin
                dy_q    <= dy_q + ONE_C;
                y_acc_q <= y_acc_q + step_y_q;
              end
            end else begin
              dx_q    <= dx_q + ONE_C;
              x_acc_q <= x_acc_q + step_x_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs come straight from registers, so coord_valid has no
  // combinational path from coord_ready and fields hold while stalled.
  assign coord_valid = (state_q == RUN);
  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == DONE);
  assign cfg_err     = cfg_err_q;
  assign x_int       = x_acc_q[Q_W-1:C_FRAC_W];
  assign x_frac      = x_acc_q[C_FRAC_W-1:0];
  assign y_int       = y_acc_q[Q_W-1:C_FRAC_W];
  assign y_frac      = y_acc_q[C_FRAC_W-1:0];
  assign sol         = coord_valid && (dx_q == '0);
  assign eol         = coord_valid && last_col;
  assign sof         = sol && (dy_q == '0);
  assign eof         = eol && last_row;

endmodule

// File: tb/tb_scale_coord_gen.sv
// Self-checking bench for scale_coord_gen: frames with random and fixed
// sizes and ready patterns, checked every cycle against an arithmetic model.
module tb_scale_coord_gen;

  localparam int CW  = 12;
  localparam int FW  = 8;
  localparam int LAT = 2 * (CW + FW) + 1;
  localparam int BIG = 32'h3fff_ffff;

  logic          clk_in1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] src_width = '0, src_height = '0, dst_width = '0, dst_height = '0;
  logic          coord_ready = 1'b0;
  logic          coord_valid;
  logic [CW-1:0] x_int, y_int;
  logic [FW-1:0] x_frac, y_frac;
  logic          sof, eof, sol, eol, busy, frame_done, cfg_err;

  scale_coord_gen #(.C_COORD_W(CW), .C_FRAC_W(FW)) dut (
    .clk_in1(clk_in1), .rst_n(rst_n), .start(start),
    .src_width(src_width), .src_height(src_height),
    .dst_width(dst_width), .dst_height(dst_height),
    .coord_ready(coord_ready), .coord_valid(coord_valid),
    .x_int(x_int), .y_int(y_int), .x_frac(x_frac), .y_frac(y_frac),
    .sof(sof), .eof(eof), .sol(sol), .eol(eol),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk_in1 = ~clk_in1;

  int cyc = 0;
  always @(posedge clk_in1) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Model of the frame in flight.
  bit frame_on = 1'b0;
  int start_cyc = BIG, done_cyc = BIG, err_cyc = -10;
  int k = 0, total = 0, m_dw = 1, m_dh = 1, m_sx = 0, m_sy = 0;
  int first_valid_cyc = -1;

  function automatic int step_of(int s, int d);
    return (s << FW) / d;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: runs every cycle, away from the active edge.
  always @(negedge clk_in1) begin : mon
    int dx, dy, xa, ya;
    bit ev, eb, ed, ee;
    if (!rst_n) begin
      chk("rst_valid", 32'(coord_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(frame_done), 0);
      chk("rst_err", 32'(cfg_err), 0);
      chk("rst_fields", {x_int, y_int, x_frac}, 0);
      chk("rst_flags", {24'd0, y_frac, sof, eof, sol, eol}, 0);
    end else begin
      if (coord_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      ev = frame_on && (cyc >= start_cyc + LAT) && (k < total);
      eb = frame_on && (cyc >= start_cyc) && (cyc <= done_cyc);
      ed = frame_on && (cyc == done_cyc);
      ee = (cyc == err_cyc);
      chk("coord_valid", 32'(coord_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(eb));
      chk("frame_done", 32'(frame_done), 32'(ed));
      chk("cfg_err", 32'(cfg_err), 32'(ee));
      if (ev) begin
        dx = k % m_dw;
        dy = k / m_dw;
        xa = dx * m_sx;
        ya = dy * m_sy;
        chk("x_int", 32'(x_int), 32'(xa >> FW));
        chk("x_frac", 32'(x_frac), 32'(xa % (1 << FW)));
        chk("y_int", 32'(y_int), 32'(ya >> FW));
        chk("y_frac", 32'(y_frac), 32'(ya % (1 << FW)));
        chk("sol", 32'(sol), 32'(dx == 0));
        chk("eol", 32'(eol), 32'(dx == m_dw - 1));
        chk("sof", 32'(sof), 32'(dx == 0 && dy == 0));
        chk("eof", 32'(eof), 32'(dx == m_dw - 1 && dy == m_dh - 1));
        if (coord_ready) begin
          k++;
          if (k == total) done_cyc = cyc + 1;
        end
      end
      if (frame_on && cyc == done_cyc + 1) frame_on = 1'b0;
    end
  end

  task automatic do_reset(int n);
    rst_n = 1'b0;
    frame_on = 1'b0;
    start = 1'b0;
    repeat (n) @(posedge clk_in1);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk_in1);
    #1;
  endtask

  // Runs one frame; rmode 0 holds ready high, 1 gives ~50% ready.
  // abort_at >= 0 asserts reset that many cycles after the start pulse.
  task automatic run_frame(int sw, int sh, int dw, int dh, int rmode, int abort_at);
    int n, budget, sc;
    @(posedge clk_in1); #1;
    src_width = CW'(sw); src_height = CW'(sh);
    dst_width = CW'(dw); dst_height = CW'(dh);
    coord_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    start = 1'b1;
    m_dw = dw; m_dh = dh; m_sx = step_of(sw, dw); m_sy = step_of(sh, dh);
    total = dw * dh; k = 0;
    start_cyc = cyc + 1; sc = start_cyc; done_cyc = BIG;
    first_valid_cyc = -1;
    frame_on = 1'b1;
    @(posedge clk_in1); #1;
    start = 1'b0;
    budget = LAT + 4 * total + 100;
    n = 0;
    while (frame_on && n < budget) begin
      if (abort_at >= 0 && n == abort_at) begin
        do_reset(3);
        return;
      end
      coord_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      start = (done_cyc == BIG) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
      src_width = CW'($urandom_range(0, 4095)); src_height = CW'($urandom_range(0, 4095));
      dst_width = CW'($urandom_range(0, 4095)); dst_height = CW'($urandom_range(0, 4095));
      @(posedge clk_in1); #1;
      n++;
    end
    start = 1'b0;
    if (frame_on) begin
      miscompares++;
      $display("FAIL frame_timeout: got %0d of %0d transfers after %0d cycles", k, total, n);
      do_reset(2);
    end else begin
      chk("first_valid_latency", 32'(first_valid_cyc - sc), 32'(LAT));
      chk("transfer_count", 32'(k), 32'(dw * dh));
    end
  endtask

  initial begin
    // Literal pins for the model itself.
    chk("model_step_708", 32'(step_of(640, 708)), 32'd231);
    chk("model_step_518", 32'(step_of(480, 518)), 32'd237);
    chk("model_step_320", 32'(step_of(640, 320)), 32'd512);
    chk("model_dx2_int", 32'((2 * step_of(640, 708)) >> FW), 32'd1);
    chk("model_dx2_frac", 32'((2 * step_of(640, 708)) % 256), 32'd206);
    chk("model_last_x", 32'((319 * step_of(640, 320)) >> FW), 32'd638);
    chk("model_last_y", 32'((239 * step_of(480, 240)) >> FW), 32'd478);

    do_reset(3);

    run_frame(20, 10, 20, 10, 0, -1);              // 1:1, step 256
    run_frame(640, 480, 708, 518, 0, LAT + 1430);  // reset mid-RUN, row 1 seen
    run_frame(640, 480, 320, 3, 0, -1);            // 2:1 downscale
    run_frame(640, 480, 708, 518, 0, 30);          // reset during DIV_Y
    run_frame(640, 480, 708, 3, 1, -1);            // upscale after reset, stalls

    // Zero destination width: cfg_err only.
    @(posedge clk_in1); #1;
    src_width = 12'd640; src_height = 12'd480; dst_width = 12'd0; dst_height = 12'd480;
    start = 1'b1; err_cyc = cyc + 1;
    @(posedge clk_in1); #1;
    start = 1'b0;
    repeat (50) @(posedge clk_in1);
    #1;

    run_frame(640, 480, 1, 1, 0, -1);              // single-pixel frame
    run_frame(7, 5, 13, 9, 1, -1);
    for (int f = 0; f < 10; f++)
      run_frame($urandom_range(1, 4095), $urandom_range(1, 4095),
                $urandom_range(1, 40), $urandom_range(1, 40), f % 2, -1);

    repeat (3) @(posedge clk_in1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scale_coord_gen.md
# scale_coord_gen

Parametrised source-coordinate generator for the bicubic/bilinear RGB scalers. On each frame start it latches the source and destination sizes and computes fixed-point horizontal and vertical step ratios with a serial divider. It then streams one source coordinate per destination pixel (integer part plus fractional weight) over a valid/ready handshake to the interpolation datapath. Unlike the fixed-size scaler front ends, sizes are runtime values re-latched per frame, and the coordinate and fraction widths are parameters.

## Interface
- C_COORD_W, 12, width of all size and integer-coordinate fields
- C_FRAC_W, 8, fractional bits of step and coordinate; Q_W = C_COORD_W + C_FRAC_W
- clk_in1  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  frame start request; sampled only in IDLE
- src_width, src_height  in  C_COORD_W  source size; latched on accepted start
- dst_width, dst_height  in  C_COORD_W  destination size; latched on accepted start
- coord_ready  in  1  downstream accepts the current coordinate
- coord_valid  out  1  coordinate fields valid
- x_int, y_int  out  C_COORD_W  integer source coordinate
- x_frac, y_frac  out  C_FRAC_W  fractional weight
- sof, eof, sol, eol  out  1  first/last pixel of frame, first/last pixel of row; qualified by coord_valid
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last coordinate is accepted
- cfg_err  out  1  one-cycle pulse when start is rejected for a zero size

## Operation
- States: IDLE, DIV_X, DIV_Y, RUN, DONE.
- IDLE, start=1:
  - If any of the four sizes is 0: pulse cfg_err and stay in IDLE.
  - Otherwise: latch all sizes and go to DIV_X.
- DIV_X: restoring serial division, one quotient bit per cycle, Q_W cycles.
  - Computes step_x = floor((src_width << C_FRAC_W) / dst_width), Q_W bits.
  - Then go to DIV_Y.
- DIV_Y: same division for step_y from src_height and dst_height. Then go to RUN with x_acc = y_acc = 0 and dx = dy = 0.
- RUN output fields:
  - x_int = x_acc[Q_W-1:C_FRAC_W], x_frac = x_acc[C_FRAC_W-1:0]; y fields from y_acc the same way.
- Mapping is top-left aligned: x_acc = dx*step_x, built by repeated addition. No multiplier.
  - Because step_x is truncated, x_int ≤ src_width-1 by construction. The same holds for y. No clamp is needed.
- Coordinate accepted when coord_valid && coord_ready:
  - Not end of row: dx++, x_acc += step_x.
  - End of row (dx = dst_width-1): dx = 0, x_acc = 0, dy++, y_acc += step_y.
- Flags:
  - sol = (dx == 0); eol = (dx == dst_width-1)
  - sof = sol && dy == 0; eof = eol && dy == dst_height-1
- Acceptance with eof=1: go to DONE with coord_valid = 0. DONE lasts one cycle and pulses frame_done, then returns to IDLE.
- start outside IDLE is ignored. Size inputs outside an accepted start are ignored; sizes may change between frames.
- dst = 1 in an axis: step = src << C_FRAC_W, and only coordinate 0 is generated in that axis.

## Timing
- Reset values: all outputs 0; state IDLE; accumulators, counters and steps 0.
- Reset is asynchronous. Asserting it mid-frame or mid-division returns everything to reset values immediately. No frame_done is generated.
- Let edge 0 be the edge that accepts start. Then:
  - busy = 1 after edge 0.
  - DIV_X iterates on edges 1..Q_W.
  - DIV_Y iterates on edges Q_W+1..2·Q_W.
  - coord_valid = 1 after edge 2·Q_W+1 (41 with default parameters).
- cfg_err pulses for the cycle following the sampling edge.
- Handshake:
  - While coord_valid && !coord_ready, all coordinate fields and flags are held stable.
  - coord_valid never drops in RUN until eof is accepted.
  - coord_valid does not depend combinationally on coord_ready.
- With coord_ready held at 1, throughput is one coordinate per clock. A frame has dst_width·dst_height transfers.
- frame_done pulses in the cycle after the eof transfer. busy falls on the following edge. The earliest next start is sampled on the edge where busy is 0.

## Test plan
- 640×480 → 640×480, ready=1:
  - step_x = step_y = 256.
  - x_int = dx, x_frac = 0 for all pixels; 307200 transfers; frame_done once.
  - First valid after edge 41.
- 640×480 → 708×518:
  - step_x = 231, step_y = 237.
  - dx=1 → (0,231); dx=2 → (1,206).
  - Row 1 has y_int = 0, y_frac = 237; the last pixel has x_int ≤ 639.
  - Sizes change back-to-back across two frames and are re-latched per frame.
- 640×480 → 320×240:
  - step = 512; dx=1 → x_int = 2, x_frac = 0.
  - Last pixel is (638, 478).
- Random coord_ready (≈50 % duty):
  - Fields hold while stalled; no transfer lost or duplicated.
  - Transfer count = dst_width·dst_height; sol/eol/sof/eof each on the correct transfer.
- dst_width = 0 with start:
  - cfg_err pulses for one cycle; busy stays 0; no coord_valid.
  - A later valid start works normally.
- rst_n low during DIV_Y, and separately mid-RUN:
  - All outputs 0 immediately; no frame_done.
  - A new start after release produces a complete, correct frame.
